tlk2711_link_ctrl: RTL
======================

Name: tlk2711_link_ctrl

Overview:
Parametrised TX link controller for one TLK2711 SerDes, one instance per device. Runs the power-up sequence: holds the device disabled, then asserts ENABLE/LCKREFN. On request it streams framed test traffic on the 16-bit TX bus: sync idles, then SOF, header, payload, EOF and gap, repeated. Selectable payload modes, device PRBS/loopback control and a clean stop handshake. Start/stop/mode come from a VIO in the clk_80 domain.

Parameters:
LOCK_DLY, 1024, cycles after reset with o_enable=0/o_lckrefn=0 before device is enabled (>=2)
SYNC_WORDS, 16, idle words sent after start before first SOF (>=1)
FRAME_WORDS, 1024, payload words per frame (1..65535)
GAP_WORDS, 8, idle words between EOF and next SOF (>=1)

Ports:
clk  in  1  TX word clock (80 MHz, also drives gtx_clk)
arst_n  in  1  asynchronous active-low reset
i_start  in  1  level; rising edge starts traffic
i_stop  in  1  level; rising edge requests stop
i_mode  in  3  traffic mode, sampled on accepted start
o_stop_ack  out  1  one-cycle pulse when stop completes
o_txd  out  16  TX data
o_tkmsb  out  1  K-flag, upper byte
o_tklsb  out  1  K-flag, lower byte
o_loopen  out  1  device near-end loopback
o_prbsen  out  1  device internal PRBS
o_enable  out  1  device enable
o_lckrefn  out  1  device lock-to-reference (active-low)
o_testen  out  1  device test enable, constant 0
o_busy  out  1  1 from accepted start until stop_ack
o_frame_cnt  out  32  frames completed since reset, wraps

Behaviour:
- Reset: every output 0 (o_txd=0x0000). FSM=PWRUP. Edge registers 0. PRBS state 0x7FFF. frame_cnt 0.
- All outputs registered. o_txd/K-flags show the word for the current state one cycle later.
- Words: IDLE = 0xC5BC, tklsb=1, tkmsb=0. SOF = 0xFBFB, both K. EOF = 0xFDFD, both K. HDR = frame_cnt[15:0], no K. Payload has no K.
- PWRUP: count LOCK_DLY cycles, then o_enable=1 and o_lckrefn=1 together, go IDLE. Start/stop edges during PWRUP are discarded.
- IDLE: send IDLE words. On start edge (stop edge not in the same cycle):
  - latch i_mode; o_busy=1; reset PRBS state to 0x7FFF.
  - mode 3: go DEVPRBS. Any other mode: go SYNC.
- SYNC: SYNC_WORDS idle words, then SOF.
- SOF (1 word), HDR (1 word), DATA (FRAME_WORDS words), EOF (1 word).
- At EOF, frame_cnt increments. HDR carries the pre-increment value.
- After EOF, GAP sends GAP_WORDS idle words, then SOF.
- Payload by latched mode:
  - 0: word index 0..FRAME_WORDS-1 within the frame.
  - 1: alternating 0xA5A5, 0x5A5A, starting 0xA5A5 each frame.
  - 2: PRBS-15 (x^15+x^14+1), 16 bits per word, MSB first. State carries across frames.
  - 4: as mode 0, with o_loopen=1 from start until stop_ack.
  - 5-7: as mode 0.
- DEVPRBS: o_prbsen=1, o_txd sends IDLE words, no frames, frame_cnt frozen.
- Stop edge is latched as stop_pending. Where it takes effect:
  - SYNC or GAP: go IDLE next cycle.
  - SOF, HDR or DATA: current frame completes through EOF, then go IDLE.
  - DEVPRBS: go IDLE next cycle.
- On entering IDLE from a run: o_stop_ack pulses 1 cycle; o_busy, o_loopen, o_prbsen clear in the same cycle.
- Start edge while busy: ignored. Stop edge while idle: ignored, no ack. Start and stop edge in the same IDLE cycle: both dropped.
- Mode changes while busy: ignored.
- Reset mid-run: immediate return to reset values and PWRUP. A frame in flight is abandoned, no EOF.

Test Plan:
1. Release reset, LOCK_DLY=16 -> o_enable=o_lckrefn=0 for 16 cycles, then both 1; o_txd=0xC5BC, tklsb=1.
2. Mode 0, FRAME_WORDS=4, SYNC_WORDS=2, GAP_WORDS=2, pulse start -> stream is C5BC×2, FBFB(K), 0000, 0000..0003, FDFD(K), C5BC×2, FBFB, 0001, …; o_frame_cnt=1 after first EOF.
3. Mode 2, start -> first payload word equals PRBS-15 from seed 0x7FFF matching reference model; second frame continues the sequence.
4. Stop edge at payload word 1 of frame -> words 2,3 and EOF still sent; o_stop_ack single pulse on first IDLE cycle; o_busy=0.
5. Mode 3 start -> o_prbsen=1, o_frame_cnt unchanged; stop -> o_prbsen=0 with o_stop_ack pulse next cycle. Mode 4 -> o_loopen=1 for the run.
6. Start+stop same cycle -> no run, no ack. Assert arst_n low mid-DATA -> all outputs 0 immediately; PWRUP restarts.

Source files
------------

// File: rtl/tlk2711_link_ctrl.sv
// TX link controller for one TLK2711 SerDes: power-up sequencing, framed
// test traffic on the 16-bit TX bus, device PRBS/loopback control and a
// clean stop handshake. Every output is a register that follows the FSM
// state by one cycle.
module tlk2711_link_ctrl #(
  parameter int LOCK_DLY    = 1024,
  parameter int SYNC_WORDS  = 16,
  parameter int FRAME_WORDS = 1024,
  parameter int GAP_WORDS   = 8
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic [2:0]  i_mode,
  output logic        o_stop_ack,
  output logic [15:0] o_txd,
  output logic        o_tkmsb,
  output logic        o_tklsb,
  output logic        o_loopen,
  output logic        o_prbsen,
  output logic        o_enable,
  output logic        o_lckrefn,
  output logic        o_testen,
  output logic        o_busy,
  output logic [31:0] o_frame_cnt
);

  localparam int M1   = (LOCK_DLY > FRAME_WORDS) ? LOCK_DLY : FRAME_WORDS;
  localparam int M2   = (SYNC_WORDS > GAP_WORDS) ? SYNC_WORDS : GAP_WORDS;
  localparam int MAXV = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXV + 1);

  localparam logic [15:0] W_IDLE = 16'hC5BC;
  localparam logic [15:0] W_SOF  = 16'hFBFB;
  localparam logic [15:0] W_EOF  = 16'hFDFD;

  typedef enum logic [3:0] {
    S_PWRUP, S_IDLE, S_SYNC, S_SOF, S_HDR, S_DATA, S_EOF, S_GAP, S_DEVPRBS
  } state_t;

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic [14:0]   prbs;
  logic [2:0]    mode;
  logic          start_q, stop_q, stop_pend, was_run;
  logic          start_edge, stop_edge, stop_req, run, accept;
  logic [30:0]   prbs_nx;

  logic [15:0]   txd_c;
  logic          tkmsb_c, tklsb_c, loopen_c, prbsen_c, enable_c, busy_c, ack_c;

  // Sixteen steps of x^15+x^14+1; first generated bit lands in word MSB.
  // Returns {word, next_state}.
  function automatic logic [30:0] prbs16(input logic [14:0] seed);
    logic [14:0] s;
    logic [15:0] w;
    logic        b;
    s = seed;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      b = s[14] ^ s[13];
      w = {w[14:0], b};
      s = {s[13:0], b};
    end
    return {w, s};
  endfunction

  assign prbs_nx    = prbs16(prbs);
  assign start_edge = i_start & ~start_q;
  assign stop_edge  = i_stop & ~stop_q;
  assign run        = (state != S_PWRUP) && (state != S_IDLE);
  assign stop_req   = stop_pend | stop_edge;
  // A simultaneous stop edge cancels the start.
  assign accept     = (state == S_IDLE) & start_edge & ~stop_edge;
  assign o_testen   = 1'b0;

  // State register plus the counters and latches that travel with it
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= S_PWRUP;
      cnt         <= '0;
      prbs        <= 15'h7FFF;
      mode        <= '0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      stop_pend   <= 1'b0;
      was_run     <= 1'b0;
      o_frame_cnt <= '0;
    end else begin
      state   <= nxt;
      start_q <= i_start;
      stop_q  <= i_stop;
      was_run <= run;
      cnt     <= (nxt != state) ? '0 : cnt + CW'(1);
      if (accept) begin
        mode <= i_mode;
        prbs <= 15'h7FFF;
      end else if (state == S_DATA && mode == 3'd2) begin
        prbs <= prbs_nx[14:0];
      end
      if (nxt == S_IDLE)        stop_pend <= 1'b0;
      else if (run & stop_edge) stop_pend <= 1'b1;
      if (state == S_EOF) o_frame_cnt <= o_frame_cnt + 32'd1;
    end
  end

  // Next-state: power-up delay, run sequencing and stop handling
  always_comb begin
    nxt = state;
    case (state)
      S_PWRUP:   if (cnt == CW'(LOCK_DLY - 2)) nxt = S_IDLE;
      S_IDLE:    if (accept) nxt = (i_mode == 3'd3) ? S_DEVPRBS : S_SYNC;
      S_SYNC:    if (stop_req) nxt = S_IDLE;
                 else if (cnt == CW'(SYNC_WORDS - 1)) nxt = S_SOF;
      S_SOF:     nxt = S_HDR;
      S_HDR:     nxt = S_DATA;
      S_DATA:    if (cnt == CW'(FRAME_WORDS - 1)) nxt = S_EOF;
      S_EOF:     nxt = stop_req ? S_IDLE : S_GAP;
      S_GAP:     if (stop_req) nxt = S_IDLE;
                 else if (cnt == CW'(GAP_WORDS - 1)) nxt = S_SOF;
      S_DEVPRBS: if (stop_req) nxt = S_IDLE;
      default:   nxt = S_PWRUP;
    endcase
  end

  // Output decode: TX word, K-flags and device control for the current state
  always_comb begin
    txd_c    = '0;
    tkmsb_c  = 1'b0;
    tklsb_c  = 1'b0;
    enable_c = (state != S_PWRUP);
    busy_c   = run;
    ack_c    = (state == S_IDLE) & was_run;
    loopen_c = run & (mode == 3'd4);
    prbsen_c = (state == S_DEVPRBS);
    case (state)
      S_IDLE, S_SYNC, S_GAP, S_DEVPRBS: begin
        txd_c   = W_IDLE;
        tklsb_c = 1'b1;
      end
      S_SOF: begin
        txd_c   = W_SOF;
        tkmsb_c = 1'b1;
        tklsb_c = 1'b1;
      end
      S_HDR: txd_c = o_frame_cnt[15:0];
      S_DATA: begin
        case (mode)
          3'd1:    txd_c = cnt[0] ? 16'h5A5A : 16'hA5A5;
          3'd2:    txd_c = prbs_nx[30:15];
          default: txd_c = 16'(cnt);
        endcase
      end
      S_EOF: begin
        txd_c   = W_EOF;
        tkmsb_c = 1'b1;
        tklsb_c = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      o_txd      <= '0;
      o_tkmsb    <= 1'b0;
      o_tklsb    <= 1'b0;
      o_loopen   <= 1'b0;
      o_prbsen   <= 1'b0;
      o_enable   <= 1'b0;
      o_lckrefn  <= 1'b0;
      o_busy     <= 1'b0;
      o_stop_ack <= 1'b0;
    end else begin
      o_txd      <= txd_c;
      o_tkmsb    <= tkmsb_c;
      o_tklsb    <= tklsb_c;
      o_loopen   <= loopen_c;
      o_prbsen   <= prbsen_c;
      o_enable   <= enable_c;
      o_lckrefn  <= enable_c;
      o_busy     <= busy_c;
      o_stop_ack <= ack_c;
    end
  end

endmodule
